// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues reads to a synchronous instruction
// memory and buffers the returned words in a show-ahead prefetch FIFO for decode.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic [15:0]           fifo_data [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop, ret_eof, room;

  // Returns arriving while halted are squashed; an EOF return also blocks the
  // read that would otherwise issue in the same cycle.
  always_comb begin
    state_d = state_q;
    push    = inflight_q && (state_q == FETCH);
    ret_eof = push && (mem_rdata == 16'h0000);
    room    = (count + CW'(inflight_q)) < CW'(DEPTH);
    if (redirect_valid)
      state_d = FETCH;
    else if (ret_eof)
      state_d = HALT;
    mem_en = rst && (state_q == FETCH) && !redirect_valid && room && !ret_eof;
  end

  assign mem_addr    = pc_q;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? fifo_data[rd_ptr] : 16'h0000;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;
  assign halted      = (state_q == HALT) && (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= FETCH;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      inflight_q <= mem_en;
      if (mem_en) begin
        pc_q          <= pc_q + ADDR_WIDTH'(1);
        inflight_pc_q <= pc_q;
      end
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc_q;
    end
  end

endmodule
